uart_tx: RTL and testbench

UART serial transmitter: the transmit-side counterpart to the receive path and its baud-rate enable generator. It accepts one byte per valid/ready handshake and serialises it onto `tx` as start bit, data bits LSB-first, optional parity, and stop bits. Bit timing comes from an internal divisor counter loaded from `baud_div`. The block sits between the CPU-facing UART register file and the pad.

---
 rtl/uart_tx.sv | 154 +++++++++++++++
 tb/tb_uart_tx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART serial transmitter.
// Serialises one DATA_BITS-wide word per valid/ready handshake as
// start bit, data bits LSB-first, optional parity bit, then STOP_BITS stop bits.
// Every bit lasts (period+1) clocks; period is latched from baud_div at accept.
// Optional feature macro: UART_TX_PARITY_EN (adds the parity bit; PARITY_ODD
// selects odd parity when set, even otherwise).
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [15:0]          baud_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  // Elaboration-time parameter legality checks.
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be 5..8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          cnt_q;
  logic [15:0]          period_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           bit_idx_q;
  logic                 stop_idx_q;
`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`endif
  logic                 tx_q, busy_q, ready_q;
  logic                 tx_d, busy_d, ready_d;

  logic accept, bit_end, last_data, last_stop;

  assign accept    = tx_valid && ready_q;
  // Compare before increment so period 16'hFFFF never needs a 17th bit.
  assign bit_end   = (cnt_q == period_q);
  assign last_data = (bit_idx_q == 3'(DATA_BITS - 1));
  assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Frame datapath: latch word/period at accept, then time and shift bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      period_q   <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else if (state_q == IDLE) begin
      if (accept) begin
        cnt_q      <= '0;
        period_q   <= baud_div;
        shift_q    <= tx_data;
        bit_idx_q  <= '0;
        stop_idx_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
        par_q      <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
      end
    end else begin
      cnt_q <= bit_end ? 16'd0 : cnt_q + 16'd1;
      if (bit_end && state_q == DATA) begin
        shift_q   <= shift_q >> 1;
        bit_idx_q <= bit_idx_q + 3'd1;
      end
      if (bit_end && state_q == STOP) stop_idx_q <= stop_idx_q + 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = START;
      START:  if (bit_end) state_d = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (bit_end && last_data) state_d = PARITY;
      PARITY: if (bit_end) state_d = STOP;
`else
      DATA:   if (bit_end && last_data) state_d = STOP;
`endif
      STOP:   if (bit_end && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state, so the pad sees a registered level.
  always_comb begin
    tx_d    = 1'b1;
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    case (state_d)
      START:  tx_d = 1'b0;
      // At a data bit boundary the shift happens on this edge, so look one ahead.
      DATA:   tx_d = (state_q == DATA && bit_end) ? shift_q[1] : shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_ready = ready_q;
  // High during the final cycle of the last stop bit.
  assign tx_done  = (state_q == STOP) && bit_end && last_stop;

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx (default instance plus a STOP_BITS=2 instance).
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [11:0] FR_A5 = 12'b010101001010;
  localparam logic [11:0] FR_07 = 12'b011000001110;
  localparam logic [11:0] FR_55 = 12'h4AA;
  localparam logic [11:0] FR_FF = 12'h5FE;
`else
  localparam int NB = 10;
  localparam logic [11:0] FR_A5 = 12'b001101001010;
  localparam logic [11:0] FR_55 = 12'h2AA;
  localparam logic [11:0] FR_FF = 12'h3FE;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready, tx, tx_busy, tx_done;
  logic        tx_valid2 = 1'b0;
  logic        tx_ready2, tx2, tx_busy2, tx_done2;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  uart_tx dut (
    .clock(clock), .reset(reset), .baud_div(baud_div), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  uart_tx #(.STOP_BITS(2)) dut2 (
    .clock(clock), .reset(reset), .baud_div(baud_div), .tx_data(tx_data),
    .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx(tx2), .tx_busy(tx_busy2),
    .tx_done(tx_done2)
  );

  task automatic present(input logic [7:0] d, input logic [15:0] b, input string name);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_before: got %b want 1", name, tx_ready);
    end
    tx_data  = d;
    baud_div = b;
    tx_valid = 1'b1;
  endtask

  // Called at the negedge where the word is presented; walks the whole frame.
  task automatic check_frame(input logic [11:0] frame, input int per, input bit hold,
                             input logic [7:0] next_d, input logic [15:0] next_b,
                             input string name);
    int f;
    logic exp;
    f = NB * (per + 1);
    for (int k = 1; k <= f; k++) begin
      @(negedge clock);
      exp = frame[(k - 1) / (per + 1)];
      checks++;
      if (tx !== exp) begin
        errors++;
        $display("FAIL %s_tx k=%0d: got %b want %b", name, k, tx, exp);
      end
      checks++;
      if (tx_done !== (k == f)) begin
        errors++;
        $display("FAIL %s_done k=%0d: got %b want %b", name, k, tx_done, (k == f));
      end
      if (k == 1) begin
        checks++;
        if (tx_ready !== 1'b0 || tx_busy !== 1'b1) begin
          errors++;
          $display("FAIL %s_hs k=1: ready=%b busy=%b want 0/1", name, tx_ready, tx_busy);
        end
        if (hold) tx_data = next_d;
        else tx_valid = 1'b0;
        baud_div = next_b;
      end
    end
    @(negedge clock);
    checks++;
    if (tx_ready !== 1'b1 || tx_done !== 1'b0 || tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: ready=%b done=%b tx=%b busy=%b want 1/0/1/0",
               name, tx_ready, tx_done, tx, tx_busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (tx !== 1'b1 || tx_ready !== 1'b0 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: tx=%b ready=%b busy=%b done=%b want 1/0/0/0",
               tx, tx_ready, tx_busy, tx_done);
    end
    checks++;
    if (tx2 !== 1'b1 || tx_ready2 !== 1'b0 || tx_busy2 !== 1'b0 || tx_done2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals2: tx=%b ready=%b busy=%b done=%b want 1/0/0/0",
               tx2, tx_ready2, tx_busy2, tx_done2);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (tx_ready !== 1'b1 || tx_ready2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b/%b want 1/1", tx_ready, tx_ready2);
    end
  endtask

  task automatic test_basic;
    present(8'hA5, 16'd3, "basic");
    check_frame(FR_A5, 3, 1'b0, 8'h00, 16'd3, "basic");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    present(8'hA5, 16'd3, "par_a5");
    check_frame(FR_A5, 3, 1'b0, 8'h00, 16'd3, "par_a5");
    present(8'h07, 16'd3, "par_07");
    check_frame(FR_07, 3, 1'b0, 8'h00, 16'd3, "par_07");
  endtask
`endif

  task automatic test_back_to_back;
    present(8'h55, 16'd0, "b2b1");
    check_frame(FR_55, 0, 1'b1, 8'hFF, 16'd0, "b2b1");
    check_frame(FR_FF, 0, 1'b0, 8'h00, 16'd0, "b2b2");
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle k=%0d: tx=%b busy=%b want 1/0", k, tx, tx_busy);
      end
    end
  endtask

  task automatic test_baud_change;
    present(8'hA5, 16'd3, "baudchg");
    check_frame(FR_A5, 3, 1'b0, 8'h00, 16'd0, "baudchg");
  endtask

  task automatic test_baud_max;
    int highs;
    highs = 0;
    present(8'h01, 16'hFFFF, "baudmax");
    for (int k = 1; k <= 65536; k++) begin
      @(negedge clock);
      if (k == 1) tx_valid = 1'b0;
      if (tx !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL baudmax_start: high cycles=%0d want 0", highs);
    end
    @(negedge clock);
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL baudmax_bit0: tx=%b busy=%b want 1/1", tx, tx_busy);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    baud_div = 16'd3;
  endtask

  task automatic test_reset_mid;
    int dones;
    dones = 0;
    present(8'hA5, 16'd3, "rstmid");
    for (int k = 1; k <= 18; k++) begin
      @(negedge clock);
      if (k == 1) tx_valid = 1'b0;
      dones += int'(tx_done);
    end
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_bit3: got %b want 0", tx);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: tx=%b busy=%b done=%b ready=%b want 1/0/0/0",
               tx, tx_busy, tx_done, tx_ready);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready: ready=%b busy=%b want 1/0", tx_ready, tx_busy);
    end
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      dones += int'(tx_done);
    end
    checks++;
    if (dones != 0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_nodone: dones=%0d tx=%b want 0/1", dones, tx);
    end
  endtask

  task automatic test_reset_handshake;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    reset    = 1'b1;
    @(negedge clock);
    checks++;
    if (tx_busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL rsths_busy: busy=%b tx=%b want 0/1", tx_busy, tx);
    end
    reset    = 1'b0;
    tx_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL rsths_idle: ready=%b busy=%b tx=%b want 1/0/1", tx_ready, tx_busy, tx);
    end
  endtask

  task automatic test_hygiene;
    int f, dones, busys, lows;
    f = NB * 2;
    dones = 0; busys = 0; lows = 0;
    present(8'h0F, 16'd1, "hyg");
    for (int k = 1; k <= f; k++) begin
      @(negedge clock);
      dones += int'(tx_done);
      tx_data  = 8'h00;
      tx_valid = (k < f) ? k[0] : 1'b0;
    end
    for (int k = 0; k < 3 * f; k++) begin
      @(negedge clock);
      dones += int'(tx_done);
      busys += int'(tx_busy);
      lows  += int'(!tx);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL hyg_dones: got %0d want 1", dones);
    end
    checks++;
    if (busys != 0 || lows != 0) begin
      errors++;
      $display("FAIL hyg_extra: busy cycles=%0d low cycles=%0d want 0/0", busys, lows);
    end
  endtask

  task automatic test_stop2;
    int f;
    f = (NB + 1) * 2;
    checks++;
    if (tx_ready2 !== 1'b1) begin
      errors++;
      $display("FAIL stop2_ready_before: got %b want 1", tx_ready2);
    end
    tx_data   = 8'h00;
    baud_div  = 16'd1;
    tx_valid2 = 1'b1;
    for (int k = 1; k <= f; k++) begin
      @(negedge clock);
      if (k == 1) tx_valid2 = 1'b0;
      checks++;
      if (tx2 !== (k > f - 4)) begin
        errors++;
        $display("FAIL stop2_tx k=%0d: got %b want %b", k, tx2, (k > f - 4));
      end
      checks++;
      if (tx_done2 !== (k == f)) begin
        errors++;
        $display("FAIL stop2_done k=%0d: got %b want %b", k, tx_done2, (k == f));
      end
    end
    @(negedge clock);
    checks++;
    if (tx_ready2 !== 1'b1 || tx_busy2 !== 1'b0) begin
      errors++;
      $display("FAIL stop2_end: ready=%b busy=%b want 1/0", tx_ready2, tx_busy2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_baud_change();
    test_reset_mid();
    test_reset_handshake();
    test_hygiene();
    test_stop2();
    test_baud_max();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
